// File: rtl/grant_collector_pkg.sv
// -----------------------------------------------------------------------------
// grant_collector_pkg
// Types and helpers shared by the token arbiter, the client controllers and
// grant_collector.
//   selection   : client identifier, A/B/C, with X meaning "nobody owns it"
//   SRC_W       : width of the out_src code carried with each FIFO word
//   sel_mask()  : one-hot {C,B,A} mask for a selection (X -> all zero)
//   src_code()  : out_src encoding of a selection (A=0, B=1, C=2)
// -----------------------------------------------------------------------------
package grant_collector_pkg;

    typedef enum logic [1:0] {
        A = 2'd0,
        B = 2'd1,
        C = 2'd2,
        X = 2'd3
    } selection;

    localparam int SRC_W = 2;

    function automatic logic [2:0] sel_mask(input selection s);
        logic [2:0] m;
        m = 3'b000;
        case (s)
            A:       m = 3'b001;
            B:       m = 3'b010;
            C:       m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    function automatic logic [SRC_W-1:0] src_code(input selection s);
        return SRC_W'(s);
    endfunction

endpackage

// File: rtl/grant_collector_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered occupancy count.
//   clk, rst_n      : clock, synchronous active-low reset (pointers/count only)
//   push, push_data : write request and word; ignored while full
//   pop             : read request; ignored while empty
//   full, empty     : derived from the registered count
//   head            : word at the read pointer (undefined while empty)
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/grant_collector.sv
// -----------------------------------------------------------------------------
// grant_collector
// Shared sink behind the three-client token arbiter. Accepts write words only
// from the client holding the grant, queues them as {src, data} in a FIFO and
// raises a sticky violation flag whenever grant exclusivity is broken.
//   clk, rst_n           : clock, synchronous active-low reset
//   ackA/B/C             : per-client grants
//   validA/B/C, dataA/B/C: per-client write strobe and word
//   out_ready            : sink takes the head word this cycle
//   out_valid            : FIFO non-empty
//   out_data, out_src    : head word and its writer (A=0, B=1, C=2); 0 when empty
//   full                 : FIFO holds DEPTH words
//   violation            : sticky mutual-exclusion error, cleared by reset only
//   drop_cnt             : saturating count of owner words rejected while full
// -----------------------------------------------------------------------------
module grant_collector
    import grant_collector_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ackA,
    input  logic              ackB,
    input  logic              ackC,
    input  logic              validA,
    input  logic              validB,
    input  logic              validC,
    input  logic [DATA_W-1:0] dataA,
    input  logic [DATA_W-1:0] dataB,
    input  logic [DATA_W-1:0] dataC,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [SRC_W-1:0]  out_src,
    output logic              full,
    output logic              violation,
    output logic [7:0]        drop_cnt
);

    localparam int ENTRY_W = DATA_W + SRC_W;

    selection          owner_q, owner_d;
    selection          cur_owner;
    logic              violation_q, violation_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic [2:0]        ack_vec, valid_vec, owner_mask, cur_mask;
    logic              multi_ack, ack_viol, valid_viol, viol_now;
    logic              owner_valid, push, pop, drop;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] push_word;
    logic [ENTRY_W-1:0] push_entry, head_entry;

    assign ack_vec   = {ackC, ackB, ackA};
    assign valid_vec = {validC, validB, validA};
    assign multi_ack = (ack_vec & (ack_vec - 3'd1)) != 3'd0;

    always_comb begin
        cur_owner = X;
        push_word = '0;
        case (ack_vec)
            3'b001: begin cur_owner = A; push_word = dataA; end
            3'b010: begin cur_owner = B; push_word = dataB; end
            3'b100: begin cur_owner = C; push_word = dataC; end
            default: begin cur_owner = X; push_word = '0; end
        endcase
    end

    assign owner_mask = sel_mask(owner_q);
    assign cur_mask   = sel_mask(cur_owner);

    // With no registered owner only overlapping acks are illegal; once a client
    // owns the grant, any other ack (even as its own falls) is a handover
    // without the mandatory idle cycle.
    assign ack_viol    = (owner_q == X) ? multi_ack : |(ack_vec & ~owner_mask);
    assign valid_viol  = |(valid_vec & ~cur_mask);
    assign viol_now    = ack_viol | valid_viol;
    assign owner_valid = |(valid_vec & cur_mask);

    assign push       = owner_valid && !viol_now && !fifo_full;
    assign drop       = owner_valid && !viol_now && fifo_full;
    assign pop        = !fifo_empty && out_ready;
    assign push_entry = {src_code(cur_owner), push_word};

    always_comb begin
        owner_d     = owner_q;
        violation_d = violation_q | viol_now;
        drop_cnt_d  = drop_cnt_q;
        if (owner_q == X) begin
            owner_d = cur_owner;
        end else if (ack_vec == owner_mask) begin
            owner_d = owner_q;
        end else begin
            owner_d = X;
        end
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q     <= X;
            violation_q <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            owner_q     <= owner_d;
            violation_q <= violation_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_entry)
    );

    // Head is masked while empty so stale, unreset storage never shows.
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : head_entry[DATA_W-1:0];
    assign out_src   = fifo_empty ? '0 : head_entry[ENTRY_W-1 -: SRC_W];
    assign full      = fifo_full;
    assign violation = violation_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_grant_collector.sv
// -----------------------------------------------------------------------------
// tb_grant_collector
// Directed bench for grant_collector: a vector table for single-owner traffic
// and FIFO fill/drop/drain, plus hand sequences for grant-overlap, handover,
// non-owner writes and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_grant_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ackA, ackB, ackC;
    logic       validA, validB, validC;
    logic [7:0] dataA, dataB, dataC;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_src;
    logic       full;
    logic       violation;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    grant_collector #(.DATA_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ackA      (ackA),
        .ackB      (ackB),
        .ackC      (ackC),
        .validA    (validA),
        .validB    (validB),
        .validC    (validC),
        .dataA     (dataA),
        .dataB     (dataB),
        .dataC     (dataC),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .full      (full),
        .violation (violation),
        .drop_cnt  (drop_cnt)
    );

    typedef struct {
        logic [2:0] ack;     // {C,B,A}
        logic [2:0] vld;     // {C,B,A}
        logic [7:0] data;    // driven on all three data buses
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_data;
        logic [1:0] e_src;
        logic       e_full;
        logic       e_viol;
        logic [7:0] e_drop;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic [2:0] ack, input logic [2:0] vld,
                                input logic [7:0] data, input logic rdy,
                                input logic ev, input logic [7:0] ed,
                                input logic [1:0] es, input logic ef,
                                input logic eviol, input logic [7:0] edrop);
        vec_t v;
        v.ack = ack; v.vld = vld; v.data = data; v.rdy = rdy;
        v.e_valid = ev; v.e_data = ed; v.e_src = es;
        v.e_full = ef; v.e_viol = eviol; v.e_drop = edrop;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] ack, input logic [2:0] vld,
                         input logic [7:0] data, input logic rdy);
        ackA = ack[0]; ackB = ack[1]; ackC = ack[2];
        validA = vld[0]; validB = vld[1]; validC = vld[2];
        dataA = data; dataB = data; dataC = data;
        out_ready = rdy;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(3'b000, 3'b000, 8'h00, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(3'b000, 3'b000, 8'h00, 1'b0);
        step();
        step();
        chk("rst out_valid", out_valid, 0);
        chk("rst full", full, 0);
        chk("rst violation", violation, 0);
        chk("rst drop_cnt", drop_cnt, 0);
        chk("rst out_data", out_data, 0);
        chk("rst out_src", out_src, 0);
        chk("rst owner", dut.owner_q, 3);
        rst_n = 1'b1;

        //            ack     vld     data  rdy  ev ed     es ef vi drop
        vecs[0]  = mk(3'b001, 3'b001, 8'h11, 1, 1, 8'h11, 0, 0, 0, 0);
        vecs[1]  = mk(3'b001, 3'b001, 8'h22, 1, 1, 8'h22, 0, 0, 0, 0);
        vecs[2]  = mk(3'b001, 3'b000, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
        vecs[3]  = mk(3'b000, 3'b000, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[4]  = mk(3'b010, 3'b010, 8'h31, 0, 1, 8'h31, 1, 0, 0, 0);
        vecs[5]  = mk(3'b010, 3'b010, 8'h32, 0, 1, 8'h31, 1, 0, 0, 0);
        vecs[6]  = mk(3'b010, 3'b010, 8'h33, 0, 1, 8'h31, 1, 0, 0, 0);
        vecs[7]  = mk(3'b010, 3'b010, 8'h34, 0, 1, 8'h31, 1, 1, 0, 0);
        vecs[8]  = mk(3'b010, 3'b010, 8'h35, 0, 1, 8'h31, 1, 1, 0, 1);
        vecs[9]  = mk(3'b010, 3'b010, 8'h36, 0, 1, 8'h31, 1, 1, 0, 2);
        vecs[10] = mk(3'b000, 3'b000, 8'h00, 1, 1, 8'h32, 1, 0, 0, 2);
        vecs[11] = mk(3'b000, 3'b000, 8'h00, 1, 1, 8'h33, 1, 0, 0, 2);
        vecs[12] = mk(3'b000, 3'b000, 8'h00, 1, 1, 8'h34, 1, 0, 0, 2);
        vecs[13] = mk(3'b000, 3'b000, 8'h00, 1, 0, 8'h00, 0, 0, 0, 2);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].ack, vecs[i].vld, vecs[i].data, vecs[i].rdy);
            step();
            chk($sformatf("v%0d out_valid", i), out_valid, vecs[i].e_valid);
            chk($sformatf("v%0d out_data", i), out_data, vecs[i].e_data);
            chk($sformatf("v%0d out_src", i), out_src, vecs[i].e_src);
            chk($sformatf("v%0d full", i), full, vecs[i].e_full);
            chk($sformatf("v%0d violation", i), violation, vecs[i].e_viol);
            chk($sformatf("v%0d drop_cnt", i), drop_cnt, vecs[i].e_drop);
        end

        // Overlapping grants with A writing: no push, sticky violation.
        do_reset();
        drive(3'b101, 3'b001, 8'h99, 1'b0);
        step();
        chk("overlap violation", violation, 1);
        chk("overlap no push", out_valid, 0);
        drive(3'b000, 3'b000, 8'h00, 1'b0);
        step();
        drive(3'b001, 3'b001, 8'h44, 1'b0);
        step();
        chk("clean push valid", out_valid, 1);
        chk("clean push data", out_data, 8'h44);
        chk("clean sticky violation", violation, 1);
        drive(3'b000, 3'b000, 8'h00, 1'b1);
        step();
        chk("idle sticky violation", violation, 1);
        do_reset();
        chk("violation cleared", violation, 0);

        // Same-edge handover A -> B.
        do_reset();
        drive(3'b001, 3'b000, 8'h00, 1'b0);
        step();
        drive(3'b010, 3'b000, 8'h00, 1'b0);
        step();
        chk("handover violation", violation, 1);

        // Handover with one idle cycle is legal.
        do_reset();
        drive(3'b001, 3'b000, 8'h00, 1'b0);
        step();
        drive(3'b000, 3'b000, 8'h00, 1'b0);
        step();
        drive(3'b010, 3'b000, 8'h00, 1'b0);
        step();
        chk("idle handover violation", violation, 0);
        drive(3'b010, 3'b010, 8'h77, 1'b0);
        step();
        chk("idle handover data", out_data, 8'h77);
        chk("idle handover src", out_src, 1);
        chk("idle handover viol", violation, 0);

        // Non-owner write while C holds the grant.
        do_reset();
        drive(3'b100, 3'b000, 8'h00, 1'b0);
        step();
        drive(3'b100, 3'b001, 8'h55, 1'b0);
        step();
        chk("nonowner no push", out_valid, 0);
        chk("nonowner violation", violation, 1);

        // Fill, drop one, pop one (3 left), then reset mid-operation.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(3'b001, 3'b001, 8'(8'hA0 + k), 1'b0);
            step();
        end
        drive(3'b001, 3'b000, 8'h00, 1'b1);
        step();
        chk("pre-rst drop_cnt", drop_cnt, 1);
        chk("pre-rst head", out_data, 8'hA1);
        chk("pre-rst full", full, 0);
        drive(3'b001, 3'b000, 8'h00, 1'b0);
        rst_n = 1'b0;
        step();
        chk("mid-rst out_valid", out_valid, 0);
        chk("mid-rst full", full, 0);
        chk("mid-rst drop_cnt", drop_cnt, 0);
        chk("mid-rst out_data", out_data, 0);
        chk("mid-rst owner", dut.owner_q, 3);
        rst_n = 1'b1;
        drive(3'b000, 3'b000, 8'h00, 1'b0);
        step();
        chk("post-rst out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
